pcs_link_ctrl: RTL and testbench
================================

Name: pcs_link_ctrl

Overview:
Receive-side link controller for the 32-bit PCS. It sequences the RX PCS reset after transceiver bring-up, waits for block lock, and runs a Clause 49-style high-BER monitor on received sync headers. On lock loss or a persistent high BER it re-issues the RX reset after a timeout. It sits beside the PCS in the transceiver RX clock domain and drives the PCS RX reset input; status outputs go to the MAC and CSR space.

Parameters:
RESET_CYCLES, 16, width of each o_rx_reset pulse in clocks (must be ≥1)
BER_WINDOW, 40283, BER window length in clocks (125 us at 322.27 MHz)
BER_THRESH, 16, bad sync headers within one window that assert hi_ber
LOCK_TIMEOUT, 65535, clocks allowed in WAIT_LOCK or HI_BER before re-reset
CNT_W, 16, width of the internal timers (must hold max(BER_WINDOW, LOCK_TIMEOUT))

Ports:
i_clk  in  1  transceiver RX user clock
i_reset_n  in  1  asynchronous active-low reset
i_xver_rx_ready  in  1  transceiver RX reset-done/CDR ready (level)
i_block_lock  in  1  block lock status from the lock state machine
i_header  in  2  received sync header
i_header_valid  in  1  i_header qualifier
o_rx_reset  out  1  active-high synchronous reset to the PCS RX datapath
o_link_up  out  1  lock held and BER acceptable
o_hi_ber  out  1  high-BER status
o_ber_count  out  6  bad headers in the current window, saturating at 63
o_reset_count  out  8  number of RX resets issued, saturating at 255

Behaviour:
- Reset (i_reset_n=0, asynchronous): state=RESET, o_rx_reset=1, o_link_up=0, o_hi_ber=0, o_ber_count=0, o_reset_count=0, all timers=0.
- All outputs are registered; every state change shows on the outputs 1 clock after the condition that caused it.
- States:
  - RESET: hold o_rx_reset=1 for RESET_CYCLES clocks, then go to WAIT_XVER. The count starts at the first clock after reset release.
  - WAIT_XVER: o_rx_reset=1. When i_xver_rx_ready=1, go to WAIT_LOCK and clear the timer.
  - WAIT_LOCK: o_rx_reset=0; timer increments every clock.
    - i_block_lock=1 → LINK_UP; clear the BER window and o_ber_count.
    - Timer reaches LOCK_TIMEOUT-1 → RESET and increment o_reset_count.
  - LINK_UP: o_link_up=1.
    - i_block_lock=0 → WAIT_LOCK (timer cleared).
    - o_hi_ber rises → HI_BER (timer cleared).
  - HI_BER: o_link_up=0.
    - o_hi_ber falls → LINK_UP.
    - i_block_lock=0 → WAIT_LOCK.
    - Timer reaches LOCK_TIMEOUT-1 → RESET and increment o_reset_count.
  - In any non-RESET state, i_xver_rx_ready=0 → RESET (o_reset_count not incremented).
- Priority within a clock: i_xver_rx_ready loss > lock loss > timeout > hi_ber change.
- BER monitor (active only in LINK_UP and HI_BER; otherwise window timer and o_ber_count are held at 0):
  - A bad header is i_header_valid=1 with i_header ∈ {2'b00, 2'b11}.
  - The window timer counts 0..BER_WINDOW-1, then wraps.
  - o_ber_count increments on each bad header and saturates at 63.
  - o_hi_ber is set on the clock where the incremented count reaches BER_THRESH, including mid-window.
  - At window wrap: o_hi_ber is cleared if the completed window's count < BER_THRESH; o_ber_count restarts at 0.
  - A bad header on the wrap clock counts toward the new window (count=1).
- o_hi_ber is cleared on entry to RESET or WAIT_LOCK.
- o_reset_count holds at 255 once saturated.

Decomposition:
- Add to code_defs_pkg: the link_state_t enum (RESET, WAIT_XVER, WAIT_LOCK, LINK_UP, HI_BER) and the sync header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.
- Natural sub-module: ber_monitor, containing the window timer, bad-header counter and hi_ber flag, with an enable input driven by the controller.

Test Plan:
- Release reset with RESET_CYCLES=4 and i_xver_rx_ready=1 → o_rx_reset=1 for exactly 4 clocks plus 1 in WAIT_XVER, then 0; o_reset_count=0.
- i_block_lock rises 10 clocks after o_rx_reset falls → o_link_up=1 one clock later; later drop i_block_lock → o_link_up=0 next clock, state WAIT_LOCK.
- LOCK_TIMEOUT=100 with i_block_lock held 0 → o_rx_reset reasserts after 100 clocks in WAIT_LOCK; o_reset_count=1; repeat three times → 3.
- BER_WINDOW=1000, BER_THRESH=16: 16 bad headers (2'b11) in one window → o_hi_ber=1 and o_link_up=0 the clock after the 16th; a following window with 5 bad → o_hi_ber=0 at wrap, o_link_up=1.
- 15 bad headers in a window, then a bad header exactly on the wrap clock → o_hi_ber stays 0 and o_ber_count=1 in the new window.
- Assert i_reset_n=0 mid-HI_BER (asynchronously, between clock edges) → all outputs go to reset values immediately; drop i_xver_rx_ready in LINK_UP → RESET next clock with o_reset_count unchanged.

Source files
------------

// File: rtl/code_defs_pkg.sv
// Shared PCS definitions: sync header encodings, RX link controller state
// encoding and counter widths.
package code_defs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int BER_CNT_W = 6;
    localparam int RST_CNT_W = 8;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_XVER = 3'd1,
        WAIT_LOCK = 3'd2,
        LINK_UP   = 3'd3,
        HI_BER    = 3'd4
    } link_state_t;

    // Anything other than a data or control sync header is a header error.
    function automatic logic is_bad_header(input logic [1:0] hdr);
        return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
    endfunction

endpackage

// File: rtl/pcs_link_ctrl_ber.sv
// High-BER monitor: fixed-length window timer, saturating bad sync header
// counter and hi_ber flag. Everything is held at zero while disabled.
module ber_monitor
    import code_defs_pkg::*;
#(
    parameter int BER_WINDOW = 40283,
    parameter int BER_THRESH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic [1:0]           i_header,
    input  logic                 i_header_valid,
    output logic                 o_hi_ber,
    output logic                 o_hi_ber_nxt,
    output logic [BER_CNT_W-1:0] o_ber_count
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(BER_WINDOW - 1);

    logic [CNT_W-1:0]     win_tmr;
    logic [CNT_W-1:0]     win_nxt;
    logic [BER_CNT_W-1:0] cnt_base;
    logic [BER_CNT_W-1:0] cnt_nxt;
    logic                 hi_nxt;
    logic                 hi_keep;
    logic                 bad;
    logic                 wrap;

    function automatic logic [BER_CNT_W-1:0] sat_inc(input logic [BER_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign bad  = i_header_valid && is_bad_header(i_header);
    assign wrap = (win_tmr == WIN_LAST);

    // A header error on the wrap clock belongs to the new window, so the
    // completed window's verdict uses the count before this clock.
    always_comb begin
        win_nxt  = '0;
        cnt_base = '0;
        cnt_nxt  = '0;
        hi_keep  = 1'b0;
        hi_nxt   = 1'b0;
        if (i_enable) begin
            win_nxt  = wrap ? '0 : win_tmr + 1'b1;
            cnt_base = wrap ? '0 : o_ber_count;
            cnt_nxt  = bad ? sat_inc(cnt_base) : cnt_base;
            hi_keep  = wrap ? (o_hi_ber && (int'(o_ber_count) >= BER_THRESH)) : o_hi_ber;
            hi_nxt   = hi_keep || (bad && (int'(cnt_nxt) == BER_THRESH));
        end
    end

    assign o_hi_ber_nxt = hi_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            win_tmr     <= '0;
            o_ber_count <= '0;
            o_hi_ber    <= 1'b0;
        end else begin
            win_tmr     <= win_nxt;
            o_ber_count <= cnt_nxt;
            o_hi_ber    <= hi_nxt;
        end
    end

endmodule

// File: rtl/pcs_link_ctrl.sv
// RX link controller: sequences the PCS RX reset after transceiver bring-up,
// tracks block lock and high BER, and re-resets the RX path on timeout.
module pcs_link_ctrl
    import code_defs_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int BER_WINDOW   = 40283,
    parameter int BER_THRESH   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CNT_W        = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_xver_rx_ready,
    input  logic                 i_block_lock,
    input  logic [1:0]           i_header,
    input  logic                 i_header_valid,
    output logic                 o_rx_reset,
    output logic                 o_link_up,
    output logic                 o_hi_ber,
    output logic [BER_CNT_W-1:0] o_ber_count,
    output logic [RST_CNT_W-1:0] o_reset_count
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    link_state_t      state;
    link_state_t      state_nxt;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmr_nxt;
    logic             rc_inc;
    logic             lock_to;
    logic             rst_done;
    logic             up_state;
    logic             ber_en;
    logic             hi_ber_nxt;

    function automatic logic [RST_CNT_W-1:0] sat_inc(input logic [RST_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign lock_to  = (tmr == TO_LAST);
    assign rst_done = (tmr == RST_LAST);
    assign up_state = (state == LINK_UP) || (state == HI_BER);

    // The monitor runs only while the link will remain up this clock, so it
    // starts from a clean window on entry and is wiped on every exit. This
    // does not depend on hi_ber, which keeps the loop through the monitor open.
    assign ber_en = up_state && i_xver_rx_ready && i_block_lock &&
                    !((state == HI_BER) && lock_to);

    ber_monitor #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH),
        .CNT_W      (CNT_W)
    ) u_ber (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_enable       (ber_en),
        .i_header       (i_header),
        .i_header_valid (i_header_valid),
        .o_hi_ber       (o_hi_ber),
        .o_hi_ber_nxt   (hi_ber_nxt),
        .o_ber_count    (o_ber_count)
    );

    // Priority: transceiver loss, lock loss, timeout, then hi_ber change.
    always_comb begin
        state_nxt = state;
        rc_inc    = 1'b0;
        case (state)
            RESET: begin
                if (rst_done) state_nxt = WAIT_XVER;
            end
            WAIT_XVER: begin
                state_nxt = i_xver_rx_ready ? WAIT_LOCK : RESET;
            end
            WAIT_LOCK: begin
                if (!i_xver_rx_ready) begin
                    state_nxt = RESET;
                end else if (i_block_lock) begin
                    state_nxt = LINK_UP;
                end else if (lock_to) begin
                    state_nxt = RESET;
                    rc_inc    = 1'b1;
                end
            end
            LINK_UP: begin
                if (!i_xver_rx_ready) begin
                    state_nxt = RESET;
                end else if (!i_block_lock) begin
                    state_nxt = WAIT_LOCK;
                end else if (hi_ber_nxt) begin
                    state_nxt = HI_BER;
                end
            end
            HI_BER: begin
                if (!i_xver_rx_ready) begin
                    state_nxt = RESET;
                end else if (!i_block_lock) begin
                    state_nxt = WAIT_LOCK;
                end else if (lock_to) begin
                    state_nxt = RESET;
                    rc_inc    = 1'b1;
                end else if (!hi_ber_nxt) begin
                    state_nxt = LINK_UP;
                end
            end
            default: begin
                state_nxt = RESET;
            end
        endcase
    end

    // The shared timer restarts on every state change and idles where unused.
    assign tmr_nxt = ((state_nxt != state) || (state == LINK_UP) || (state == WAIT_XVER))
                   ? '0 : tmr + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= RESET;
            tmr           <= '0;
            o_rx_reset    <= 1'b1;
            o_link_up     <= 1'b0;
            o_reset_count <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            o_rx_reset <= (state_nxt == RESET) || (state_nxt == WAIT_XVER);
            o_link_up  <= (state_nxt == LINK_UP);
            if (rc_inc) o_reset_count <= sat_inc(o_reset_count);
        end
    end

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Directed bench for pcs_link_ctrl: instance A exercises reset sequencing,
// lock handling and timeouts; instance B exercises the high-BER monitor.
module tb_pcs_link_ctrl;

    logic       i_clk = 1'b0;
    logic       rst_a_n;
    logic       rst_b_n;
    logic       xver_ready;
    logic       block_lock;
    logic [1:0] header;
    logic       header_valid;

    logic       a_rx_reset, a_link_up, a_hi_ber;
    logic [5:0] a_ber_count;
    logic [7:0] a_reset_count;
    logic       b_rx_reset, b_link_up, b_hi_ber;
    logic [5:0] b_ber_count;
    logic [7:0] b_reset_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    pcs_link_ctrl #(
        .RESET_CYCLES (4),
        .BER_WINDOW   (1000),
        .BER_THRESH   (16),
        .LOCK_TIMEOUT (100),
        .CNT_W        (16)
    ) u_dut_a (
        .i_clk           (i_clk),
        .i_reset_n       (rst_a_n),
        .i_xver_rx_ready (xver_ready),
        .i_block_lock    (block_lock),
        .i_header        (header),
        .i_header_valid  (header_valid),
        .o_rx_reset      (a_rx_reset),
        .o_link_up       (a_link_up),
        .o_hi_ber        (a_hi_ber),
        .o_ber_count     (a_ber_count),
        .o_reset_count   (a_reset_count)
    );

    pcs_link_ctrl #(
        .RESET_CYCLES (4),
        .BER_WINDOW   (1000),
        .BER_THRESH   (16),
        .LOCK_TIMEOUT (4000),
        .CNT_W        (16)
    ) u_dut_b (
        .i_clk           (i_clk),
        .i_reset_n       (rst_b_n),
        .i_xver_rx_ready (xver_ready),
        .i_block_lock    (block_lock),
        .i_header        (header),
        .i_header_valid  (header_valid),
        .o_rx_reset      (b_rx_reset),
        .o_link_up       (b_link_up),
        .o_hi_ber        (b_hi_ber),
        .o_ber_count     (b_ber_count),
        .o_reset_count   (b_reset_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        rst_a_n      = 1'b0;
        rst_b_n      = 1'b0;
        xver_ready   = 1'b1;
        block_lock   = 1'b0;
        header       = 2'b01;
        header_valid = 1'b0;

        #12;
        chk("a_rst_rx_reset", a_rx_reset, 1);
        chk("a_rst_link_up", a_link_up, 0);
        chk("a_rst_hi_ber", a_hi_ber, 0);
        chk("a_rst_ber_count", a_ber_count, 0);
        chk("a_rst_reset_count", a_reset_count, 0);
        rst_a_n = 1'b1;

        // Four RESET clocks then one WAIT_XVER clock keep the PCS in reset.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_rx_reset_hold", a_rx_reset, 1);
        end
        tick();
        chk("a_rx_reset_release", a_rx_reset, 0);
        chk("a_reset_count_init", a_reset_count, 0);

        repeat (9) tick();
        chk("a_no_link_yet", a_link_up, 0);
        block_lock = 1'b1;
        tick();
        chk("a_link_up_rise", a_link_up, 1);
        chk("a_rx_reset_low_up", a_rx_reset, 0);

        block_lock = 1'b0;
        tick();
        chk("a_link_up_fall", a_link_up, 0);
        chk("a_wait_lock_no_reset", a_rx_reset, 0);

        // Lock timeout: 100 clocks in WAIT_LOCK, then a full reset sequence.
        for (int k = 1; k <= 3; k++) begin
            repeat (99) tick();
            chk("a_before_timeout", a_rx_reset, 0);
            tick();
            chk("a_timeout_reset", a_rx_reset, 1);
            chk("a_reset_count", a_reset_count, k);
            repeat (4) tick();
            chk("a_rereset_hold", a_rx_reset, 1);
            tick();
            chk("a_rereset_release", a_rx_reset, 0);
        end

        block_lock = 1'b1;
        tick();
        chk("a_relink", a_link_up, 1);
        xver_ready = 1'b0;
        tick();
        chk("a_xver_loss_reset", a_rx_reset, 1);
        chk("a_xver_loss_link", a_link_up, 0);
        chk("a_xver_loss_count", a_reset_count, 3);
        xver_ready = 1'b1;
        rst_a_n    = 1'b0;

        // Instance B: bring link up, block_lock already high.
        rst_b_n = 1'b1;
        repeat (5) tick();
        chk("b_rx_reset_release", b_rx_reset, 0);
        chk("b_no_link_yet", b_link_up, 0);
        tick();
        chk("b_link_up", b_link_up, 1);

        header       = 2'b11;
        header_valid = 1'b1;
        repeat (15) tick();
        chk("b_cnt15", b_ber_count, 15);
        chk("b_hi_ber_pre", b_hi_ber, 0);
        chk("b_link_pre", b_link_up, 1);
        tick();
        chk("b_hi_ber_set", b_hi_ber, 1);
        chk("b_link_drop", b_link_up, 0);
        chk("b_cnt16", b_ber_count, 16);
        header_valid = 1'b0;

        repeat (984) tick();
        chk("b_hi_ber_kept_wrap", b_hi_ber, 1);
        chk("b_cnt_wrap0", b_ber_count, 0);
        chk("b_link_still_down", b_link_up, 0);

        header       = 2'b00;
        header_valid = 1'b1;
        repeat (5) tick();
        chk("b_cnt5", b_ber_count, 5);
        header_valid = 1'b0;
        repeat (994) tick();
        chk("b_hi_ber_before_wrap", b_hi_ber, 1);
        tick();
        chk("b_hi_ber_clear", b_hi_ber, 0);
        chk("b_link_recover", b_link_up, 1);
        chk("b_cnt_after_clear", b_ber_count, 0);

        // 15 errors ending just before the wrap, then one on the wrap clock.
        repeat (984) tick();
        header       = 2'b11;
        header_valid = 1'b1;
        repeat (15) tick();
        chk("b_cnt15_late", b_ber_count, 15);
        chk("b_hi_ber_15", b_hi_ber, 0);
        tick();
        chk("b_cnt_wrap_bad", b_ber_count, 1);
        chk("b_hi_ber_wrap_bad", b_hi_ber, 0);
        chk("b_link_wrap_bad", b_link_up, 1);

        repeat (15) tick();
        chk("b_hi_ber_again", b_hi_ber, 1);
        chk("b_cnt16_again", b_ber_count, 16);
        chk("b_link_down_again", b_link_up, 0);
        header_valid = 1'b0;

        #3;
        rst_b_n = 1'b0;
        #1;
        chk("b_async_rx_reset", b_rx_reset, 1);
        chk("b_async_link_up", b_link_up, 0);
        chk("b_async_hi_ber", b_hi_ber, 0);
        chk("b_async_ber_count", b_ber_count, 0);
        chk("b_async_reset_count", b_reset_count, 0);

        rst_b_n = 1'b1;
        repeat (6) tick();
        chk("b_relink", b_link_up, 1);
        chk("b_relink_cnt", b_ber_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
